// File: rtl/iob_fifo_ram_ctrl.sv
// Synchronous FIFO controller for an external 2-port byte-enable RAM with a registered read port.
// Define IOB_FIFO_ALMOST_FLAGS_EN to add the w_almost_full / r_almost_empty outputs.
module iob_fifo_ram_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                w_en,
    input  logic [DATA_W-1:0]   w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [DATA_W-1:0]   r_data,
    output logic                r_valid,
    output logic                r_empty,
    output logic [ADDR_W:0]     level,
    output logic [DATA_W/8-1:0] ext_mem_w_en,
    output logic [ADDR_W-1:0]   ext_mem_w_addr,
    output logic [DATA_W-1:0]   ext_mem_w_data,
    output logic                ext_mem_r_en,
    output logic [ADDR_W-1:0]   ext_mem_r_addr,
    input  logic [DATA_W-1:0]   ext_mem_r_data
`ifdef IOB_FIFO_ALMOST_FLAGS_EN
    ,
    output logic                w_almost_full,
    output logic                r_almost_empty
`endif
);

    localparam logic [ADDR_W:0] FULL_LEVEL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] EMPTY_LEVEL = '0;

    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic              push;
    logic              pop;

    // Flags come from the level register only, so a blocked request never sees write/read-through.
    assign w_full  = (level == FULL_LEVEL);
    assign r_empty = (level == EMPTY_LEVEL);
    assign push    = w_en & ~w_full;
    assign pop     = r_en & ~r_empty;

    assign ext_mem_w_en   = {(DATA_W/8){push}};
    assign ext_mem_w_addr = w_ptr;
    assign ext_mem_w_data = w_data;
    assign ext_mem_r_en   = pop;
    assign ext_mem_r_addr = r_ptr;

    // The RAM registers its read data, so r_valid just tracks the pop by one cycle.
    assign r_data = ext_mem_r_data;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            w_ptr <= '0;
        end else if (push) begin
            w_ptr <= w_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_ptr <= '0;
        end else if (pop) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= pop;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            level <= '0;
        end else if (push && !pop) begin
            level <= level + 1'b1;
        end else if (pop && !push) begin
            level <= level - 1'b1;
        end
    end

`ifdef IOB_FIFO_ALMOST_FLAGS_EN
    localparam logic [ADDR_W:0] ALMOST_FULL_LEVEL = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE_LEVEL         = {{ADDR_W{1'b0}}, 1'b1};

    assign w_almost_full  = (level >= ALMOST_FULL_LEVEL);
    assign r_almost_empty = (level <= ONE_LEVEL);
`endif

endmodule
